axilm_bus_arb: RTL
==================

Name: axilm_bus_arb

Overview:
- Round-robin arbiter that shares one AXI-Lite master local bus between NUM_REQ requesters (CPU, DMA descriptor fetch, debug port).
- Downstream is the AXI-Lite master read/write channel pair.
- Sequences one transaction at a time: grant, one-cycle issue pulse, wait for completion or timeout, return the response to the granted requester.

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..8.
- TIMEOUT_CYC, 256: WAIT-state cycles before forced error completion; 0 disables the timeout.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- req_ena  in  NUM_REQ  per-requester request level; held until its ack.
- req_wstb  in  NUM_REQ*4  write strobes, slice i for requester i; 0 means read.
- req_addr  in  NUM_REQ*32  address, slice i.
- req_wdata  in  NUM_REQ*32  write data, slice i.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- req_rdata  out  32  read data, shared; valid while req_ack is nonzero.
- req_resp  out  2  AXI response code, shared; valid while req_ack is nonzero.
- m_ena  out  1  one-cycle transaction start to the downstream channel.
- m_wstb  out  4  latched strobes.
- m_addr  out  32  latched address.
- m_wdata  out  32  latched write data.
- m_done  in  1  downstream completion pulse.
- m_rdata  in  32  downstream read data, valid with m_done.
- m_resp  in  2  downstream RRESP/BRESP, valid with m_done.
- grant_id  out  3  index of the current or last granted requester.
- tmo_pulse  out  1  one-cycle pulse when a timeout completion is generated.

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0; rr pointer last = NUM_REQ-1, so requester 0 has highest priority first.
- Reset mid-transaction abandons it: no ack is issued, and a later m_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_ena is set:
  - Pick the first set bit searching from last+1 upward with wrap-around.
  - Latch that requester's wstb, addr and wdata into the m_* registers and set grant_id.
  - Go to ISSUE.
  - Requests arriving in the same cycle are resolved purely by the rr order.
- ISSUE: m_ena=1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT:
  - m_ena=0; the timer increments each cycle.
  - On m_done: capture m_rdata/m_resp; go to RESP.
  - On timer == TIMEOUT_CYC-1 without m_done (TIMEOUT_CYC>0): rdata=0, resp=2'b10 (SLVERR), tmo_pulse=1; go to RESP.
  - If m_done and expiry coincide, m_done wins and tmo_pulse stays 0.
- RESP:
  - req_ack[grant_id]=1 for exactly one cycle, with req_rdata/req_resp driven from the captured values.
  - Set last=grant_id; go to IDLE.
  - req_rdata/req_resp hold their values until the next RESP.
- Requester rule: deassert req_ena on the edge after seeing ack. The arbiter re-samples req_ena in the following IDLE cycle, so a requester holding req_ena issues a new transaction.
- Latency: req_ena high in IDLE at cycle 0 → m_ena at cycle 1. m_done at cycle N≥2 → ack at cycle N+1. Minimum 4 cycles request-to-ack, 1 idle cycle between transactions.
- m_done outside WAIT, including a late response after a timeout, is ignored and dropped.
- m_* address/data/strobe outputs stay stable from ISSUE through RESP.
- A request whose req_ena drops before grant is simply not served.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0.
- Timer width: $clog2(TIMEOUT_CYC+1), saturating; unused when TIMEOUT_CYC=0.

Decomposition:
- Package axilm_pkg holds:
  - the state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - MAX_REQ=8.
- Sub-module axilm_rr_pick: combinational round-robin selector with inputs req[NUM_REQ] and last[2:0], outputs valid and idx[2:0]. It is instantiated once.
- FSM, latches and timer stay in axilm_bus_arb.

Test Plan:
- Single read: req_ena[0]=1, wstb=0, addr=32'h1000_0004; m_done at cycle 2 with m_rdata=32'hDEADBEEF, m_resp=0 → m_ena pulse at cycle 1 with m_addr=32'h1000_0004; req_ack=2'b01 at cycle 3 with req_rdata=32'hDEADBEEF, req_resp=0.
- Simultaneous requests: NUM_REQ=2, both asserted at reset release and held → grants 0,1,0,1 (grant_id sequence); each ack one-hot and one cycle long.
- Write pass-through: req1 wstb=4'hF, addr=32'h20, wdata=32'h1234_5678, m_resp=2'b00 → m_wstb=4'hF and m_wdata=32'h1234_5678 stable from m_ena until the ack cycle.
- Timeout: TIMEOUT_CYC=4, m_done never asserted → tmo_pulse and ack at cycle 6 with req_resp=2'b10, req_rdata=0. A later m_done produces no ack.
- m_done at the expiry cycle: TIMEOUT_CYC=4, m_done at cycle 5 with resp=0 → req_resp=0, tmo_pulse=0.
- Reset mid-WAIT: ARESETn low for 1 cycle after m_ena → all outputs 0 immediately, no ack. A subsequent request is served normally with requester 0 first.

Source files
------------

// File: rtl/axilm_pkg.sv
// Shared types and constants for the AXI-Lite master bus arbiter.
package axilm_pkg;

    localparam int MAX_REQ = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axilm_rr_pick.sv
// Combinational round-robin selector: first set request after 'last', with wrap-around.
module axilm_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    output logic               valid,
    output logic [2:0]         idx
);

    int w_cand;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        valid  = 1'b0;
        idx    = 3'd0;
        w_cand = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = int'(last) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == w_cand) && req[j]) begin
                    valid = 1'b1;
                    idx   = 3'(j);
                end
            end
        end
    end

endmodule

// File: rtl/axilm_bus_arb.sv
// Round-robin arbiter sharing one AXI-Lite master local bus between NUM_REQ requesters,
// one transaction at a time with an optional completion timeout.
module axilm_bus_arb
    import axilm_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [NUM_REQ-1:0]     req_ena,
    input  logic [NUM_REQ*4-1:0]   req_wstb,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [31:0]            req_rdata,
    output logic [1:0]             req_resp,
    output logic                   m_ena,
    output logic [3:0]             m_wstb,
    output logic [31:0]            m_addr,
    output logic [31:0]            m_wdata,
    input  logic                   m_done,
    input  logic [31:0]            m_rdata,
    input  logic [1:0]             m_resp,
    output logic [2:0]             grant_id,
    output logic                   tmo_pulse
);

    if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ)) begin : g_bad_num_req
        $error("axilm_bus_arb: NUM_REQ must be in 2..8");
    end

    localparam int             TW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0]  TMR_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [TW-1:0]  TMR_MAX  = '1;
    localparam logic [2:0]     LAST_RST = 3'(NUM_REQ - 1);

    arb_state_e            r_state;
    logic [2:0]            r_last;
    logic [2:0]            r_grant;
    logic [TW-1:0]         r_tmr;
    logic                  r_m_ena;
    logic [3:0]            r_m_wstb;
    logic [31:0]           r_m_addr;
    logic [31:0]           r_m_wdata;
    logic [NUM_REQ-1:0]    r_ack;
    logic [31:0]           r_rdata;
    logic [1:0]            r_resp;
    logic                  r_tmo;

    logic                  w_pick_valid;
    logic [2:0]            w_pick_idx;
    logic [3:0]            w_sel_wstb;
    logic [31:0]           w_sel_addr;
    logic [31:0]           w_sel_wdata;
    logic [NUM_REQ-1:0]    w_grant_oh;
    logic                  w_tmo_hit;

    axilm_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_ena),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        w_sel_wstb  = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_idx == 3'(i)) begin
                w_sel_wstb  = req_wstb[i*4 +: 4];
                w_sel_addr  = req_addr[i*32 +: 32];
                w_sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    assign w_grant_oh = NUM_REQ'(1) << r_grant;
    assign w_tmo_hit  = (TIMEOUT_CYC > 0) && (r_tmr == TMR_LAST);

    // Outputs are registered: pulses are armed on the transition into the state they belong to.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= IDLE;
            r_last    <= LAST_RST;
            r_grant   <= 3'd0;
            r_tmr     <= '0;
            r_m_ena   <= 1'b0;
            r_m_wstb  <= 4'd0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
            r_ack     <= '0;
            r_rdata   <= 32'd0;
            r_resp    <= RESP_OKAY;
            r_tmo     <= 1'b0;
        end else begin
            r_m_ena <= 1'b0;
            r_ack   <= '0;
            r_tmo   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_idx;
                        r_m_wstb  <= w_sel_wstb;
                        r_m_addr  <= w_sel_addr;
                        r_m_wdata <= w_sel_wdata;
                        r_m_ena   <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_tmr   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_tmr != TMR_MAX) begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                    // A completion arriving on the expiry cycle takes precedence over the timeout.
                    if (m_done) begin
                        r_rdata <= m_rdata;
                        r_resp  <= m_resp;
                        r_ack   <= w_grant_oh;
                        r_state <= RESP;
                    end else if (w_tmo_hit) begin
                        r_rdata <= 32'd0;
                        r_resp  <= RESP_SLVERR;
                        r_tmo   <= 1'b1;
                        r_ack   <= w_grant_oh;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ack   = r_ack;
    assign req_rdata = r_rdata;
    assign req_resp  = r_resp;
    assign m_ena     = r_m_ena;
    assign m_wstb    = r_m_wstb;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign grant_id  = r_grant;
    assign tmo_pulse = r_tmo;

endmodule
